// File: rtl/iadder_vl_pipe.sv
// Variable-latency speculative adder: windowed approximate sum with predicted carries,
// optional one-shot correction to the exact sum, valid/ready handshake and error counter.
module iadder_vl_pipe #(
  parameter int W        = 16,
  parameter int L        = 6,
  parameter int K        = 3,
  parameter int CIN_MODE = 1,
  parameter int CORR_CYC = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  input  logic             exact_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     SUM,
  output logic             ERR,
  output logic             CORR,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] ERR_CNT
);

  localparam int N  = (W - L + K - 1) / K + 1;
  localparam int CW = (CORR_CYC > 1) ? $clog2(CORR_CYC) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OUT  = 2'd1;
  localparam logic [1:0] S_CORR = 2'd2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic [W-1:0]     approx_d;
  logic [W-1:0]     exact_d;
  logic             err_d;

  logic [1:0]       state;
  logic [CW-1:0]    corr_cnt;
  logic [W-1:0]     sum_p0;
  logic [W-1:0]     exact_p0;
  logic             err_p0;
  logic             corr_p0;
  logic [CNT_W-1:0] err_cnt;
  logic             accept;
  logic             hs_out;

  // Window 0 supplies the low L result bits with no carry-in.
  assign approx_d[L-1:0] = A[L-1:0] + B[L-1:0];

  // Upper windows: each adds L bits (clipped at the MSB) plus a guessed carry and keeps its top K bits.
  for (genvar i = 1; i < N; i++) begin : g_win
    localparam int LO  = i * K;
    localparam int WW  = (W - LO < L) ? W - LO : L;
    localparam int TW  = WW - (L - K);
    localparam int RLO = LO + L - K;
    logic cin;
    if (CIN_MODE == 1) begin : g_cin_a
      assign cin = A[(i-1)*K];
    end else begin : g_cin_zero
      assign cin = 1'b0;
    end
    assign approx_d[RLO +: TW] = TW'((A[LO +: WW] + B[LO +: WW] + WW'(cin)) >> (L - K));
  end

  assign exact_d = A + B;
  assign err_d   = (approx_d != exact_d);

  assign in_ready  = (state == S_IDLE) | ((state == S_OUT) & out_ready);
  assign accept    = in_valid & in_ready;
  assign hs_out    = (state == S_OUT) & out_ready;
  assign out_valid = (state == S_OUT);
  assign SUM       = sum_p0;
  assign ERR       = err_p0;
  assign CORR      = corr_p0;
  assign ERR_CNT   = err_cnt;

  // p0: operand results captured on accept; held until the output handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      corr_cnt <= '0;
      sum_p0   <= '0;
      exact_p0 <= '0;
      err_p0   <= 1'b0;
      corr_p0  <= 1'b0;
      err_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE, S_OUT: begin
          if (accept) begin
            sum_p0   <= approx_d;
            exact_p0 <= exact_d;
            err_p0   <= err_d;
            corr_p0  <= 1'b0;
            if (exact_mode & err_d) begin
              state    <= S_CORR;
              corr_cnt <= CW'(CORR_CYC - 1);
            end else begin
              state <= S_OUT;
            end
          end else if (hs_out) begin
            state <= S_IDLE;
          end
        end
        S_CORR: begin
          if (corr_cnt == '0) begin
            state   <= S_OUT;
            sum_p0  <= exact_p0;
            corr_p0 <= 1'b1;
          end else begin
            corr_cnt <= corr_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (clr_cnt)
        err_cnt <= '0;
      else if (hs_out & err_p0)
        err_cnt <= sat_inc(err_cnt);
    end
  end

endmodule

// File: tb/tb_iadder_vl_pipe.sv
// Bench for iadder_vl_pipe: bit-level window model, expected-result queue with due cycles,
// directed literal cases and randomized handshake traffic.
module tb_iadder_vl_pipe;
  localparam int W        = 16;
  localparam int L        = 6;
  localparam int K        = 3;
  localparam int CIN_MODE = 1;
  localparam int CORR_CYC = 1;
  localparam int CNT_W    = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     A;
  logic [W-1:0]     B;
  logic             exact_mode;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     SUM;
  logic             ERR;
  logic             CORR;
  logic             clr_cnt;
  logic [CNT_W-1:0] ERR_CNT;

  iadder_vl_pipe #(.W(W), .L(L), .K(K), .CIN_MODE(CIN_MODE), .CORR_CYC(CORR_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .exact_mode(exact_mode), .out_valid(out_valid), .out_ready(out_ready), .SUM(SUM),
    .ERR(ERR), .CORR(CORR), .clr_cnt(clr_cnt), .ERR_CNT(ERR_CNT)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         err;
    logic         corr;
    int           due;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   delivered = 0;
  logic [CNT_W-1:0] cnt_m = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Each result bit p is taken from the window whose kept K bits contain p.
  function automatic logic [W-1:0] model_approx(input logic [W-1:0] a, input logic [W-1:0] b);
    int r, ai, bi, i, lo, ww, m, cin, s;
    r = 0; ai = int'(a); bi = int'(b);
    for (int p = 0; p < W; p++) begin
      i   = (p < L) ? 0 : (p - L + K) / K;
      lo  = i * K;
      ww  = (W - lo < L) ? W - lo : L;
      m   = (1 << ww) - 1;
      cin = (i > 0 && CIN_MODE == 1) ? ((ai >> ((i - 1) * K)) & 1) : 0;
      s   = ((ai >> lo) & m) + ((bi >> lo) & m) + cin;
      r   = r | (((s >> (p - lo)) & 1) << p);
    end
    return W'(r);
  endfunction

  logic ov_exp, ir_exp;
  exp_t e;
  logic [W-1:0] ex_sum, ap_sum;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      cnt_m = '0;
    end else begin
      ov_exp = (q.size() > 0) && (cyc >= q[0].due);
      ir_exp = (q.size() == 0) || (ov_exp && out_ready);
      check("out_valid", out_valid, ov_exp);
      check("in_ready", in_ready, ir_exp);
      check("err_cnt", ERR_CNT, cnt_m);
      if (ov_exp) begin
        check("sum", SUM, q[0].sum);
        check("err", ERR, q[0].err);
        check("corr", CORR, q[0].corr);
      end
      if (ov_exp && out_ready) begin
        if (q[0].err && cnt_m != {CNT_W{1'b1}}) cnt_m = cnt_m + 1'b1;
        void'(q.pop_front());
        delivered++;
      end
      if (clr_cnt) cnt_m = '0;
      if (in_valid && ir_exp) begin
        ap_sum = model_approx(A, B);
        ex_sum = A + B;
        e.err  = (ap_sum != ex_sum);
        e.corr = exact_mode && e.err;
        e.sum  = e.corr ? ex_sum : ap_sum;
        e.due  = cyc + 1 + (e.corr ? CORR_CYC : 0);
        q.push_back(e);
      end
    end
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    step();
    A = a; B = b; exact_mode = m; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (q.size() != 0 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check("drain_empty", (q.size() == 0), 1);
  endtask

  int k, d0;
  logic acc;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; exact_mode = 1'b0;
    out_ready = 1'b0; clr_cnt = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", SUM, 0);
    check("rst_err", ERR, 0);
    check("rst_corr", CORR, 0);
    check("rst_err_cnt", ERR_CNT, 0);
    #1 rst_n = 1'b1;

    // Randomized traffic with carry-heavy operand pairs
    repeat (3000) begin
      step();
      in_valid   = ($urandom_range(0, 3) != 0);
      A          = W'($urandom);
      B          = $urandom_range(0, 1) ? W'($urandom) : W'(~A + W'($urandom_range(0, 3)));
      exact_mode = $urandom_range(0, 1) == 1;
      out_ready  = ($urandom_range(0, 3) != 0);
      clr_cnt    = ($urandom_range(0, 63) == 0);
    end
    step();
    clr_cnt = 1'b0;
    drain();

    // Back-to-back error-free stream with out_ready toggling
    d0 = delivered;
    k = 0;
    step();
    A = '0; B = W'(3); exact_mode = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    while (k < 8) begin
      @(negedge clk);
      acc = in_ready;
      step();
      out_ready = ~out_ready;
      if (acc) begin
        k++;
        A = W'(k * 5);
        B = W'(k + 3);
      end
    end
    in_valid = 1'b0;
    drain();
    check("stream_count", delivered - d0, 8);

    step(); clr_cnt = 1'b1;
    step(); clr_cnt = 1'b0;

    op(16'h0007, 16'h0001, 1'b0);
    check("d1_valid", out_valid, 1);
    check("d1_sum", SUM, 16'h0008);
    check("d1_err", ERR, 0);
    check("d1_corr", CORR, 0);

    op(16'h0FFE, 16'h0002, 1'b0);
    check("d2_valid", out_valid, 1);
    check("d2_sum", SUM, 16'h11C0);
    check("d2_err", ERR, 1);
    check("d2_corr", CORR, 0);
    check("d2_cnt_before", ERR_CNT, 0);
    step();
    @(negedge clk);
    check("d2_cnt_after", ERR_CNT, 1);

    op(16'h0FFE, 16'h0002, 1'b1);
    check("d3_valid_low", out_valid, 0);
    check("d3_in_ready_low", in_ready, 0);
    step();
    @(negedge clk);
    check("d3_valid", out_valid, 1);
    check("d3_sum", SUM, 16'h1000);
    check("d3_err", ERR, 1);
    check("d3_corr", CORR, 1);
    step();
    @(negedge clk);
    check("d3_cnt", ERR_CNT, 2);

    op(16'hFFFF, 16'h0001, 1'b1);
    check("d4_valid", out_valid, 1);
    check("d4_sum", SUM, 16'h0000);
    check("d4_err", ERR, 0);
    check("d4_corr", CORR, 0);

    // Reset asserted while a correction is in progress
    step();
    A = 16'h0FFE; B = 16'h0002; exact_mode = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_cnt", ERR_CNT, 0);
    check("mid_rst_sum", SUM, 0);
    check("mid_rst_corr", CORR, 0);
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;

    op(16'h0007, 16'h0001, 1'b0);
    check("post_rst_valid", out_valid, 1);
    check("post_rst_sum", SUM, 16'h0008);
    check("post_rst_cnt", ERR_CNT, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
